// File: rtl/toggle_period_monitor.sv
// Receive-side checker for a free-running toggling bit: measures each level run of q,
// locks after LOCK_N consecutive runs of EXP_HALF cycles, and flags short/long/stuck runs.
module toggle_period_monitor #(
   parameter int EXP_HALF = 4,
   parameter int LOCK_N   = 4,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             q,
   output logic             locked,
   output logic             err_pulse,
   output logic             err_flag,
   output logic [CNT_W-1:0] half_len,
   output logic [CNT_W-1:0] edge_cnt
);

   localparam int GOOD_W = $clog2(LOCK_N + 1);

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                q_s_q, q_s_d;
   logic                q_sd_q, q_sd_d;
   logic [CNT_W-1:0]    run_len_q, run_len_d;
   logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
   logic                locked_q, locked_d;
   logic                err_pulse_q, err_pulse_d;
   logic                err_flag_q, err_flag_d;
   logic [CNT_W-1:0]    half_len_q, half_len_d;
   logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;

   logic                edge_det;
   logic                run_at_exp;
   logic                violation;

   always_comb begin
      q_s_d       = q;
      q_sd_d      = q_s_q;
      run_len_d   = run_len_q;
      good_cnt_d  = good_cnt_q;
      state_d     = state_q;
      half_len_d  = half_len_q;
      edge_cnt_d  = edge_cnt_q;
      violation   = 1'b0;

      edge_det    = q_s_q ^ q_sd_q;
      run_at_exp  = (run_len_q == CNT_W'(EXP_HALF));

      // run_len holds the length of the level that an edge terminates
      if (edge_det) begin
         run_len_d  = CNT_W'(1);
         half_len_d = run_len_q;
         edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end else if (run_len_q != {CNT_W{1'b1}}) begin
         run_len_d = run_len_q + CNT_W'(1);
      end

      case (state_q)
         ST_SYNC: begin
            if (edge_det) begin
               state_d    = ST_MEASURE;
               good_cnt_d = '0;
            end
         end
         ST_MEASURE: begin
            if (edge_det) begin
               if (run_at_exp) begin
                  if (good_cnt_q == GOOD_W'(LOCK_N - 1)) begin
                     state_d    = ST_LOCKED;
                     good_cnt_d = GOOD_W'(LOCK_N);
                  end else begin
                     good_cnt_d = good_cnt_q + GOOD_W'(1);
                  end
               end else begin
                  violation  = 1'b1;
                  good_cnt_d = '0;
               end
            end else if (run_at_exp) begin
               // level already lasted EXP_HALF cycles with no edge: stuck
               violation = 1'b1;
               state_d   = ST_SYNC;
            end
         end
         ST_LOCKED: begin
            if (edge_det) begin
               if (!run_at_exp) begin
                  violation  = 1'b1;
                  state_d    = ST_MEASURE;
                  good_cnt_d = '0;
               end
            end else if (run_at_exp) begin
               violation = 1'b1;
               state_d   = ST_SYNC;
            end
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase

      locked_d    = (state_d == ST_LOCKED);
      err_pulse_d = violation;
      err_flag_d  = err_flag_q | violation;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_SYNC;
         q_s_q       <= 1'b0;
         q_sd_q      <= 1'b0;
         run_len_q   <= '0;
         good_cnt_q  <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_flag_q  <= 1'b0;
         half_len_q  <= '0;
         edge_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         q_s_q       <= q_s_d;
         q_sd_q      <= q_sd_d;
         run_len_q   <= run_len_d;
         good_cnt_q  <= good_cnt_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         err_flag_q  <= err_flag_d;
         half_len_q  <= half_len_d;
         edge_cnt_q  <= edge_cnt_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_flag  = err_flag_q;
   assign half_len  = half_len_q;
   assign edge_cnt  = edge_cnt_q;

endmodule

// File: tb/tb_toggle_period_monitor.sv
// Scoreboard bench for toggle_period_monitor: directed half-period sequences push expected
// per-edge and per-error records; a monitor pops them as the DUTs report edges and errors.
module tb_toggle_period_monitor;

   logic       clk;
   logic       reset;
   logic       q;
   logic       locked, err_pulse, err_flag;
   logic [7:0] half_len, edge_cnt;
   logic       locked3, err_pulse3, err_flag3;
   logic [2:0] half_len3, edge_cnt3;

   toggle_period_monitor #(.EXP_HALF(4), .LOCK_N(4), .CNT_W(8)) u_dut (
      .clk(clk), .reset(reset), .q(q),
      .locked(locked), .err_pulse(err_pulse), .err_flag(err_flag),
      .half_len(half_len), .edge_cnt(edge_cnt)
   );

   toggle_period_monitor #(.EXP_HALF(4), .LOCK_N(4), .CNT_W(3)) u_w3 (
      .clk(clk), .reset(reset), .q(q),
      .locked(locked3), .err_pulse(err_pulse3), .err_flag(err_flag3),
      .half_len(half_len3), .edge_cnt(edge_cnt3)
   );

   typedef struct {
      int gap;
      int hl;
      bit lk;
      bit err;
      bit st;
      bit ef;
   } vec_t;

   typedef struct {
      int ec;
      int hl;
      bit lk;
      bit ef;
   } exp_t;

   exp_t edge_q[$];
   int   err_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   exp_ec   = 0;
   int   prev_ec  = 0;
   bit   mon_en   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int gap, input int hl, input bit lk,
                               input bit err, input bit st, input bit ef);
      vec_t v;
      v.gap = gap; v.hl = hl; v.lk = lk; v.err = err; v.st = st; v.ef = ef;
      return v;
   endfunction

   // gap cycles after the previous toggle, flip q; expectations refer to the resulting edge
   task automatic apply(input vec_t v);
      exp_t e;
      if (v.st) err_q.push_back(exp_ec);
      repeat (v.gap) @(posedge clk);
      #1 q = ~q;
      exp_ec++;
      e.ec = exp_ec; e.hl = v.hl; e.lk = v.lk; e.ef = v.ef;
      edge_q.push_back(e);
      if (v.err) err_q.push_back(exp_ec);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_locked"},    int'(locked),    0);
      check({tag, "_err_pulse"}, int'(err_pulse), 0);
      check({tag, "_err_flag"},  int'(err_flag),  0);
      check({tag, "_half_len"},  int'(half_len),  0);
      check({tag, "_edge_cnt"},  int'(edge_cnt),  0);
      check({tag, "_w3_locked"},   int'(locked3),   0);
      check({tag, "_w3_err_flag"}, int'(err_flag3), 0);
      check({tag, "_w3_edge_cnt"}, int'(edge_cnt3), 0);
   endtask

   // monitor: one record per reported edge, one per reported error pulse
   initial begin
      exp_t e;
      int   eec;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (int'(edge_cnt) != prev_ec) begin
               if (edge_q.size() == 0) begin
                  check("unexpected_edge", int'(edge_cnt), prev_ec);
               end else begin
                  e = edge_q.pop_front();
                  check("edge_cnt", int'(edge_cnt), e.ec % 256);
                  if (e.hl >= 0) check("half_len", int'(half_len), e.hl);
                  check("locked",   int'(locked),   int'(e.lk));
                  check("err_flag", int'(err_flag), int'(e.ef));
                  check("w3_edge_cnt", int'(edge_cnt3), e.ec % 8);
                  if (e.hl >= 0) check("w3_half_len", int'(half_len3), (e.hl > 7) ? 7 : e.hl);
                  check("w3_locked", int'(locked3), int'(e.lk));
               end
            end
            if (err_pulse) begin
               if (err_q.size() == 0) begin
                  check("unexpected_err_pulse", int'(err_pulse), 0);
               end else begin
                  eec = err_q.pop_front();
                  check("err_edge_cnt", int'(edge_cnt), eec);
                  check("err_flag_on_pulse", int'(err_flag), 1);
                  check("locked_on_pulse", int'(locked), 0);
                  check("w3_err_pulse", int'(err_pulse3), 1);
               end
            end
         end
         prev_ec = int'(edge_cnt);
      end
   end

   initial begin
      reset = 1'b1;
      q     = 1'b0;
      repeat (5) @(posedge clk);
      #1 check_zero("reset");
      reset = 1'b0;
      @(posedge clk);
      #1 mon_en = 1;

      // lock: first edge syncs, then four good halves
      apply(mk(3, -1, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++) apply(mk(4, 4, (i == 3), 0, 0, 0));
      for (int i = 0; i < 2; i++) apply(mk(4, 4, 1, 0, 0, 0));

      // short half-period while locked, then relock with sticky error
      apply(mk(3, 3, 0, 1, 0, 1));
      for (int i = 0; i < 4; i++) apply(mk(4, 4, (i == 3), 0, 0, 1));
      apply(mk(4, 4, 1, 0, 0, 1));

      // q held high 20 cycles: single stuck error, edge after it only resyncs
      apply(mk(20, 20, 0, 0, 1, 1));
      for (int i = 0; i < 4; i++) apply(mk(4, 4, (i == 3), 0, 0, 1));
      apply(mk(4, 4, 1, 0, 0, 1));

      // 5-cycle half in MEASURE: stuck at run_len 4, not a long-edge error
      apply(mk(3, 3, 0, 1, 0, 1));
      apply(mk(4, 4, 0, 0, 0, 1));
      apply(mk(5, 5, 0, 0, 1, 1));
      for (int i = 0; i < 4; i++) apply(mk(4, 4, (i == 3), 0, 0, 1));
      for (int i = 0; i < 2; i++) apply(mk(4, 4, 1, 0, 0, 1));

      // one-cycle reset while locked, before the next stuck check
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      mon_en = 0;
      @(posedge clk);
      #1 check_zero("mid_reset");
      check("queue_before_mid_reset", edge_q.size() + err_q.size(), 0);
      reset  = 1'b0;
      exp_ec = 0;
      @(posedge clk);
      #1 mon_en = 1;

      apply(mk(3, -1, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++) apply(mk(4, 4, (i == 3), 0, 0, 0));
      apply(mk(4, 4, 1, 0, 0, 0));

      // stop toggling: expect one stuck error and nothing after it
      err_q.push_back(exp_ec);
      repeat (16) @(posedge clk);
      @(negedge clk);
      #1;
      check("edge_queue_empty", edge_q.size(), 0);
      check("err_queue_empty",  err_q.size(), 0);
      check("final_err_flag",   int'(err_flag), 1);
      check("final_locked",     int'(locked), 0);
      check("final_w3_err_flag", int'(err_flag3), 1);
      check("final_edge_cnt",   int'(edge_cnt), 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
